lsu_axil_sram: RTL and testbench
================================

Name: lsu_axil_sram

Overview:
AXI4-Lite-style slave data memory. Sits directly downstream of the write-back/memory stage of the multicycle core and consumes its mem_ar/r/aw/w/b channels. Holds a word-addressed internal RAM. Inserts fixed or pseudo-random response latency so the core's handshake logic is stressed in simulation.

Parameters:
DEPTH, 4096, number of 32-bit words in the RAM
BASE_ADDR, 32'h8000_0000, byte address of word 0
RAND_DELAY, 1, 1 = LFSR-derived latency, 0 = fixed latency
FIXED_DELAY, 0, extra wait cycles used when RAND_DELAY=0 (0..31)
DELAY_MASK, 8'h1f, mask applied to the LFSR value to form a random delay
INIT_FILE, "", hex image loaded with $readmemh at time 0 if non-empty

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  32  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  32  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  8  byte enables; bits [3:0] used, [7:4] ignored
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset: arready=0, rvalid=0, rdata=0, rresp=0, awready=0, wready=0, bvalid=0, bresp=0. Both FSMs go to IDLE, counters clear, LFSR=8'hA5. RAM contents are not cleared. Reset mid-transaction aborts it and no RAM write occurs.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every non-reset cycle. delay = RAND_DELAY ? (lfsr & DELAY_MASK) : FIXED_DELAY, sampled at address acceptance.
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH. Index = (addr-BASE_ADDR)>>2. addr[1:0] is ignored (word aligned).
- Read FSM R_IDLE -> R_DELAY -> R_RESP:
  - R_IDLE: arready=1. On arvalid&&arready, latch the index/range and load cnt=delay. Go to R_DELAY.
  - R_DELAY: arready=0. If cnt==0, sample RAM into rdata and set rvalid=1, rresp. Otherwise cnt--. delay 0 gives rvalid 2 cycles after the AR handshake edge; latency = delay+2.
  - R_RESP: rvalid, rdata and rresp are held stable until rready. On rvalid&&rready, rvalid=0 next cycle and the FSM returns to R_IDLE. arready rises the cycle after.
  - Out of range: rdata=0, rresp=2'b10.
- Write FSM W_IDLE -> W_DELAY -> W_RESP:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in any order or in the same cycle. Each is latched once.
  - When both are held, load cnt=delay and go to W_DELAY with awready=wready=0.
  - W_DELAY: at cnt==0, commit the RAM write using byte lanes per wstrb[3:0] (dropped if out of range), then set bvalid=1 and bresp. Otherwise cnt--.
  - W_RESP: bvalid and bresp are held until bready. On handshake the FSM returns to W_IDLE.
- The read and write FSMs are fully independent and may be active concurrently.
- Same-cycle read sample and write commit to the same word: rdata returns the old value (read-before-write).
- wstrb=0 in range: OKAY response, RAM unchanged.

Test Plan:
1. RAND_DELAY=0, FIXED_DELAY=0. AW+W same cycle, addr 0x8000_0010, data 0xDEADBEEF, strb 0x0F. Then read 0x8000_0010 -> bresp 00; rdata 0xDEADBEEF, rresp 00; rvalid exactly 2 cycles after AR handshake.
2. Write 0x0000AB00 strb 0x02 to 0x8000_0010 after scenario 1, then read -> rdata 0xDEADABEF.
3. Read 0x7FFF_FFFC and write to 0x8000_4000 (DEPTH=4096) -> rresp 10, rdata 0, bresp 10. RAM unchanged at index 0 and 4095.
4. awvalid at cycle 0, wvalid at cycle 3, rready held low 5 cycles on a read -> exactly one RAM write after W captured. rvalid/rdata/rresp stable across the stall; single response per request.
5. Assert rst during R_DELAY and W_DELAY (FIXED_DELAY=10) -> next cycle all outputs at reset values; target word keeps its prior value.
6. RAND_DELAY=1, 200 back-to-back random reads/writes against a scoreboard -> all data match; every latency in 2..33 cycles; at least 4 distinct latencies observed.

Source files
------------

// File: rtl/lsu_axil_sram.sv
// lsu_axil_sram: AXI4-Lite-style slave data memory with
// independent read/write FSMs and fixed or LFSR-driven latency.
module lsu_axil_sram #(
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter bit          RAND_DELAY  = 1'b1,
  parameter int          FIXED_DELAY = 0,
  parameter logic [7:0]  DELAY_MASK  = 8'h1f,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} w_state_t;

  logic [31:0] ram [DEPTH];

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [7:0]    lfsr;
  logic [7:0]    delay;
  logic          up;
  logic [8:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_ok;
  logic [8:0]    w_cnt;
  logic [AW-1:0] w_idx;
  logic          w_ok;
  logic          aw_held;
  logic          w_held;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;

  logic ar_fire, aw_fire, w_fire;
  logic aw_have, w_have, w_go;
  logic w_commit;
  logic unused;

  function automatic logic hit(input logic [31:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [AW-1:0] idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  assign unused = ^wstrb[7:4];

  assign delay = RAND_DELAY ? (lfsr & DELAY_MASK)
                            : 8'(FIXED_DELAY);

  assign ar_fire = arvalid && arready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign aw_have = aw_held || aw_fire;
  assign w_have  = w_held || w_fire;
  assign w_go    = (w_state == W_IDLE) && aw_have && w_have;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      up      <= 1'b0;
      lfsr    <= 8'hA5;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      up      <= 1'b1;
      lfsr    <= {lfsr[6:0],
                  lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DELAY;
      R_DELAY: if (r_cnt == '0) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (w_go) w_next = W_DELAY;
      W_DELAY: if (w_cnt == '0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    arready = up && (r_state == R_IDLE);
    rvalid  = (r_state == R_RESP);
    awready = up && (w_state == W_IDLE) && !aw_held;
    wready  = up && (w_state == W_IDLE) && !w_held;
    bvalid  = (w_state == W_RESP);
  end

  // Counters load delay+1 so a zero delay still costs two edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ok    <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      w_cnt   <= '0;
      w_idx   <= '0;
      w_ok    <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp   <= '0;
    end else begin
      if (ar_fire) begin
        r_cnt <= {1'b0, delay} + 9'd1;
        r_idx <= idx(araddr);
        r_ok  <= hit(araddr);
      end else if (r_state == R_DELAY) begin
        if (r_cnt == '0) begin
          rdata <= r_ok ? ram[r_idx] : '0;
          rresp <= r_ok ? 2'b00 : 2'b10;
        end else begin
          r_cnt <= r_cnt - 9'd1;
        end
      end
      if (aw_fire) begin
        aw_held <= 1'b1;
        w_idx   <= idx(awaddr);
        w_ok    <= hit(awaddr);
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb[3:0];
      end
      if (w_go) begin
        w_cnt   <= {1'b0, delay} + 9'd1;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else if (w_state == W_DELAY) begin
        if (w_cnt == '0) begin
          bresp <= w_ok ? 2'b00 : 2'b10;
        end else begin
          w_cnt <= w_cnt - 9'd1;
        end
      end
    end
  end

  assign w_commit = !rst && w_ok &&
                    (w_state == W_DELAY) &&
                    (w_cnt == '0);

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_commit && w_strb[b])
        ram[w_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_lsu_axil_sram.sv
// tb_lsu_axil_sram: directed and random checks of lsu_axil_sram
// against a word-array reference memory.
module tb_lsu_axil_sram;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  logic rst;

  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] awaddr  [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [31:0] wdata   [2];
  logic [7:0]  wstrb   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic [1:0]  bresp   [2];

  logic [31:0] mdl [2][DEPTH];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsu_axil_sram #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .RAND_DELAY(1'b0), .FIXED_DELAY(0),
    .DELAY_MASK(8'h1f), .INIT_FILE("")
  ) u_fix (
    .clk(clk), .rst(rst),
    .arvalid(arvalid[0]), .arready(arready[0]),
    .araddr(araddr[0]),
    .rvalid(rvalid[0]), .rready(rready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]),
    .awvalid(awvalid[0]), .awready(awready[0]),
    .awaddr(awaddr[0]),
    .wvalid(wvalid[0]), .wready(wready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]),
    .bvalid(bvalid[0]), .bready(bready[0]),
    .bresp(bresp[0])
  );

  lsu_axil_sram #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .RAND_DELAY(1'b1), .FIXED_DELAY(0),
    .DELAY_MASK(8'h1f), .INIT_FILE("")
  ) u_rnd (
    .clk(clk), .rst(rst),
    .arvalid(arvalid[1]), .arready(arready[1]),
    .araddr(araddr[1]),
    .rvalid(rvalid[1]), .rready(rready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]),
    .awvalid(awvalid[1]), .awready(awready[1]),
    .awaddr(awaddr[1]),
    .wvalid(wvalid[1]), .wready(wready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]),
    .bvalid(bvalid[1]), .bready(bready[1]),
    .bresp(bresp[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_mem(input logic [31:0] a);
    return a >= BASE && a <= BASE + 32'(4*DEPTH - 1);
  endfunction

  function automatic int word(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic chk_rst(input int d);
    check("rst_arready", arready[d], 0);
    check("rst_rvalid", rvalid[d], 0);
    check("rst_rdata", rdata[d], 0);
    check("rst_rresp", rresp[d], 0);
    check("rst_awready", awready[d], 0);
    check("rst_wready", wready[d], 0);
    check("rst_bvalid", bvalid[d], 0);
    check("rst_bresp", bresp[d], 0);
  endtask

  task automatic rd(input int d, input logic [31:0] a,
                    input int stall,
                    output logic [31:0] data,
                    output logic [1:0] resp,
                    output int lat);
    int n;
    n = 0;
    arvalid[d] = 1'b1;
    araddr[d] = a;
    while (!arready[d] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("ar_timeout", n, 0);
    tick();
    arvalid[d] = 1'b0;
    lat = 0;
    while (!rvalid[d] && lat < 200) begin
      tick();
      lat++;
    end
    if (!rvalid[d]) check("r_timeout", lat, 0);
    data = rdata[d];
    resp = rresp[d];
    for (int i = 0; i < stall; i++) begin
      tick();
      check("r_hold_v", rvalid[d], 1);
      check("r_hold_d", rdata[d], data);
      check("r_hold_r", rresp[d], resp);
    end
    rready[d] = 1'b1;
    tick();
    rready[d] = 1'b0;
    check("r_single", rvalid[d], 0);
  endtask

  task automatic wr(input int d, input logic [31:0] a,
                    input logic [31:0] data,
                    input logic [7:0] strb,
                    input int ag, input int wg,
                    input int stall,
                    output logic [1:0] resp,
                    output int lat);
    bit aw_done;
    bit w_done;
    int c;
    aw_done = 0;
    w_done = 0;
    c = 0;
    awaddr[d] = a;
    wdata[d] = data;
    wstrb[d] = strb;
    while (!(aw_done && w_done) && c < 200) begin
      awvalid[d] = !aw_done && c >= ag;
      wvalid[d] = !w_done && c >= wg;
      check("b_early", bvalid[d], 0);
      if (aw_done) check("aw_once", awready[d], 0);
      if (w_done) check("w_once", wready[d], 0);
      if (awvalid[d] && awready[d]) aw_done = 1;
      if (wvalid[d] && wready[d]) w_done = 1;
      tick();
      c++;
    end
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b0;
    if (c >= 200) check("aw_w_timeout", c, 0);
    lat = 0;
    while (!bvalid[d] && lat < 200) begin
      tick();
      lat++;
    end
    if (!bvalid[d]) check("b_timeout", lat, 0);
    resp = bresp[d];
    for (int i = 0; i < stall; i++) begin
      tick();
      check("b_hold_v", bvalid[d], 1);
      check("b_hold_r", bresp[d], resp);
    end
    bready[d] = 1'b1;
    tick();
    bready[d] = 1'b0;
    check("b_single", bvalid[d], 0);
  endtask

  task automatic mwr(input int d, input logic [31:0] a,
                     input logic [31:0] data,
                     input logic [7:0] strb,
                     input int ag, input int wg,
                     input int stall, output int lat);
    logic [1:0] resp;
    wr(d, a, data, strb, ag, wg, stall, resp, lat);
    if (in_mem(a)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[d][word(a)][8*b +: 8] = data[8*b +: 8];
    end
    check("bresp", resp, in_mem(a) ? 2'b00 : 2'b10);
  endtask

  task automatic mrd(input int d, input logic [31:0] a,
                     input int stall, output int lat);
    logic [31:0] data;
    logic [1:0] resp;
    rd(d, a, stall, data, resp, lat);
    check("rdata", data, in_mem(a) ? mdl[d][word(a)] : 32'h0);
    check("rresp", resp, in_mem(a) ? 2'b00 : 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] data;
    logic [1:0] resp;
    logic [31:0] a;
    int lat;
    bit [63:0] seen;
    int distinct;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      arvalid[d] = 0; araddr[d] = '0; rready[d] = 0;
      awvalid[d] = 0; awaddr[d] = '0; wvalid[d] = 0;
      wdata[d] = '0; wstrb[d] = '0; bready[d] = 0;
    end
    repeat (3) tick();
    chk_rst(0);
    chk_rst(1);
    rst = 1'b0;
    tick();
    check("arready_up", arready[0], 1);
    check("awready_up", awready[0], 1);

    // scenario 1/2: fixed zero delay, byte lanes
    wr(0, BASE + 32'h10, 32'hDEADBEEF, 8'h0F, 0, 0, 0, resp, lat);
    check("s1_bresp", resp, 2'b00);
    check("s1_wlat", lat, 2);
    rd(0, BASE + 32'h10, 0, data, resp, lat);
    check("s1_rdata", data, 32'hDEADBEEF);
    check("s1_rresp", resp, 2'b00);
    check("s1_rlat", lat, 2);
    mdl[0][4] = 32'hDEADBEEF;
    wr(0, BASE + 32'h10, 32'h0000AB00, 8'h02, 0, 0, 0, resp, lat);
    check("s2_bresp", resp, 2'b00);
    rd(0, BASE + 32'h13, 0, data, resp, lat);
    check("s2_rdata", data, 32'hDEADABEF);
    mdl[0][4] = 32'hDEADABEF;

    // scenario 3: range edges
    mwr(0, BASE, 32'h01234567, 8'h0F, 0, 0, 0, lat);
    mwr(0, BASE + 32'h3FFC, 32'h89ABCDEF, 8'hFF, 0, 0, 0, lat);
    rd(0, 32'h7FFF_FFFC, 0, data, resp, lat);
    check("s3_oor_rdata", data, 32'h0);
    check("s3_oor_rresp", resp, 2'b10);
    wr(0, 32'h8000_4000, 32'hFFFFFFFF, 8'h0F, 0, 0, 0, resp, lat);
    check("s3_oor_bresp", resp, 2'b10);
    mrd(0, BASE, 0, lat);
    mrd(0, BASE + 32'h3FFC, 0, lat);
    mwr(0, BASE + 32'h3FFC, 32'h0, 8'hF0, 0, 0, 0, lat);
    mrd(0, BASE + 32'h3FFC, 0, lat);

    // scenario 4: AW before W, read with rready stall
    mwr(0, BASE + 32'h20, 32'hCAFEF00D, 8'h0F, 0, 3, 2, lat);
    check("s4_wlat", lat, 2);
    mrd(0, BASE + 32'h20, 5, lat);
    check("s4_rlat", lat, 2);
    mwr(0, BASE + 32'h24, 32'h5A5A5A5A, 8'h0F, 4, 1, 0, lat);
    mrd(0, BASE + 32'h24, 1, lat);

    // scenario 5: reset during both delay phases
    arvalid[0] = 1; araddr[0] = BASE + 32'h10;
    awvalid[0] = 1; awaddr[0] = BASE + 32'h10;
    wvalid[0] = 1; wdata[0] = 32'h55555555;
    wstrb[0] = 8'h0F;
    tick();
    arvalid[0] = 0; awvalid[0] = 0; wvalid[0] = 0;
    rst = 1'b1;
    tick();
    chk_rst(0);
    rst = 1'b0;
    tick();
    mrd(0, BASE + 32'h10, 0, lat);
    check("s5_keep", mdl[0][4], 32'hDEADABEF);

    // scenario 6: random traffic, random latency
    seen = '0;
    for (int i = 0; i < 32; i++)
      mwr(1, BASE + 32'(4*i), $urandom, 8'h0F, 0, 0, 0, lat);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1)
          a = BASE - 32'(4 * $urandom_range(1, 4));
        else
          a = BASE + 32'(4*DEPTH) + 32'(4 * $urandom_range(0, 7));
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, 31))
                 + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1)
        mwr(1, a, $urandom, 8'($urandom),
            $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 2), lat);
      else
        mrd(1, a, $urandom_range(0, 2), lat);
      check("s6_lat", lat >= 2 && lat <= 33, 1);
      if (lat < 64) seen[lat] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 64; i++) distinct += int'(seen[i]);
    check("s6_distinct", distinct >= 4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
